// File: rtl/cdb_arbiter.sv
// Round-robin arbiter that grants one functional-unit result per cycle onto the
// registered common data bus, with flush, zero-index error flagging and a broadcast counter.
module cdb_arbiter #(
    parameter int N_SRC           = 4,
    parameter int ROB_ENTRY_WIDTH = 8,
    parameter int DATA_WIDTH      = 32,
    localparam int SRC_W          = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic [N_SRC-1:0]                 src_valid,
    output logic [N_SRC-1:0]                 src_ready,
    input  logic [N_SRC*ROB_ENTRY_WIDTH-1:0] src_rob_index,
    input  logic [N_SRC*DATA_WIDTH-1:0]      src_data,
    output logic                             cdb_valid,
    output logic [ROB_ENTRY_WIDTH-1:0]       cdb_rob_index,
    output logic [DATA_WIDTH-1:0]            cdb_data,
    output logic [SRC_W-1:0]                 cdb_src,
    output logic                             err_zero_index,
    output logic [15:0]                      grant_count
);

    logic [ROB_ENTRY_WIDTH-1:0] rob_idx_a [N_SRC];
    logic [DATA_WIDTH-1:0]      data_a    [N_SRC];

    for (genvar g = 0; g < N_SRC; g++) begin : g_unpack
        assign rob_idx_a[g] = src_rob_index[g*ROB_ENTRY_WIDTH +: ROB_ENTRY_WIDTH];
        assign data_a[g]    = src_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    logic [SRC_W-1:0]           rr_ptr_q, rr_ptr_d;
    logic                       cdb_valid_q, cdb_valid_d;
    logic [ROB_ENTRY_WIDTH-1:0] cdb_idx_q, cdb_idx_d;
    logic [DATA_WIDTH-1:0]      cdb_data_q, cdb_data_d;
    logic [SRC_W-1:0]           cdb_src_q, cdb_src_d;
    logic                       err_q, err_d;
    logic [15:0]                cnt_q, cnt_d;

    logic                       grant_found;
    logic [SRC_W-1:0]           grant_idx;
    logic [SRC_W-1:0]           cand;
    logic                       grant_zero;

    // Scan from rr_ptr upward with wrap; the first valid source wins.
    always_comb begin
        // NOTE: every combinational output gets a default before any branch so no latch is inferred.
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        src_ready   = '0;
        if (!rst && !flush) begin
            for (int k = 0; k < N_SRC; k++) begin
                cand = SRC_W'((int'(rr_ptr_q) + k) % N_SRC);
                if (!grant_found && src_valid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
        end
        if (grant_found) begin
            src_ready[grant_idx] = 1'b1;
        end
    end

    assign grant_zero = grant_found && (rob_idx_a[grant_idx] == '0);

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        cdb_valid_d = 1'b0;
        cdb_idx_d   = '0;
        cdb_data_d  = '0;
        cdb_src_d   = cdb_src_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        if (flush) begin
            rr_ptr_d = '0;
        end else if (grant_found) begin
            rr_ptr_d = (grant_idx == SRC_W'(N_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
            // A zero index still consumes its slot but never reaches the ROB.
            if (grant_zero) begin
                err_d = 1'b1;
            end else begin
                cdb_valid_d = 1'b1;
                cdb_idx_d   = rob_idx_a[grant_idx];
                cdb_data_d  = data_a[grant_idx];
                cdb_src_d   = grant_idx;
                if (cnt_q != 16'hFFFF) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            cdb_valid_q <= 1'b0;
            cdb_idx_q   <= '0;
            cdb_data_q  <= '0;
            cdb_src_q   <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            cdb_valid_q <= cdb_valid_d;
            cdb_idx_q   <= cdb_idx_d;
            cdb_data_q  <= cdb_data_d;
            cdb_src_q   <= cdb_src_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
        end
    end

    assign cdb_valid      = cdb_valid_q;
    assign cdb_rob_index  = cdb_idx_q;
    assign cdb_data       = cdb_data_q;
    assign cdb_src        = cdb_src_q;
    assign err_zero_index = err_q;
    assign grant_count    = cnt_q;

endmodule
